// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with runtime parity, configurable stop
// length and a one-entry holding buffer allowing back-to-back frames.
module uart_tx_frame #(
    parameter int DBIT    = 8,
    parameter int OVS     = 16,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    input  logic [1:0]      par_mode,
    output logic            tx_ready,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic            tx
);
    localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
    localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] shift_q, shift_d, buf_q, buf_d;
    logic [1:0]      bpm_q, bpm_d;
    logic            full_q, full_d, pen_q, pen_d, par_q, par_d, tx_q, tx_d;
    logic            load, last_s, last_n;

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        shift_d      = shift_q;
        buf_d        = buf_q;
        bpm_d        = bpm_q;
        full_d       = full_q;
        pen_d        = pen_q;
        par_d        = par_q;
        load         = 1'b0;
        tx_done_tick = 1'b0;
        last_s       = s_q == SW'(OVS - 1);
        last_n       = n_q == NW'(DBIT - 1);
        if (tx_start && !full_q) begin
            buf_d  = din;
            bpm_d  = par_mode;
            full_d = 1'b1;
        end
        case (state_q)
            IDLE: load = full_q;
            START: if (s_tick) begin
                if (last_s) begin
                    state_d = DATA;
                    s_d     = '0;
                end else s_d = s_q + SW'(1);
            end
            DATA: if (s_tick) begin
                if (last_s) begin
                    s_d     = '0;
                    shift_d = shift_q >> 1;
                    if (last_n) state_d = pen_q ? PARITY : STOP;
                    else n_d = n_q + NW'(1);
                end else s_d = s_q + SW'(1);
            end
            PARITY: if (s_tick) begin
                if (last_s) begin
                    state_d = STOP;
                    s_d     = '0;
                end else s_d = s_q + SW'(1);
            end
            STOP: if (s_tick) begin
                if (s_q == SW'(SB_TICK - 1)) begin
                    tx_done_tick = 1'b1;
                    state_d      = IDLE;
                    load         = full_q;
                end else s_d = s_q + SW'(1);
            end
            default: state_d = IDLE;
        endcase
        // parity is taken from the buffered word so it never sees the shifted register
        if (load) begin
            state_d = START;
            shift_d = buf_q;
            pen_d   = ^bpm_q;
            par_d   = (^buf_q) ^ bpm_q[1];
            s_d     = '0;
            n_d     = '0;
            full_d  = 1'b0;
        end
        tx_d = (state_d == START)  ? 1'b0 :
               (state_d == DATA)   ? shift_d[0] :
               (state_d == PARITY) ? par_d : 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shift_q <= '0;
            buf_q   <= '0;
            bpm_q   <= '0;
            full_q  <= 1'b0;
            pen_q   <= 1'b0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            buf_q   <= buf_d;
            bpm_q   <= bpm_d;
            full_q  <= full_d;
            pen_q   <= pen_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_ready = ~full_q;
    assign tx_busy  = state_q != IDLE;
    assign tx       = tx_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: three transmitter configurations checked every cycle against a
// tick-counting frame model, plus a frame table and hand-written corner sequences.
module tb_uart_tx_frame;
    localparam int OVS = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       st[3], ts[3];
    logic [8:0] dn[3];
    logic [1:0] pm[3];
    logic       o_tx[3], o_rdy[3], o_busy[3], o_done[3];
    logic       s_tx[3], s_rdy[3], s_busy[3], s_done[3], s_ts[3];

    int db[3] = '{8, 8, 5};
    int sb[3] = '{16, 32, 16};
    int mode[3];
    int cc, checks, failures;

    bit         m_full[3], m_busy[3];
    int         m_rem[3], m_t[3];
    logic [8:0] m_buf[3], m_dat[3];
    logic [1:0] m_bpm[3], m_pm[3];

    always #5 clk = ~clk;

    uart_tx_frame #(.DBIT(8), .OVS(16), .SB_TICK(16)) u0 (
        .clk(clk), .reset(reset), .s_tick(ts[0]), .tx_start(st[0]), .din(dn[0][7:0]),
        .par_mode(pm[0]), .tx_ready(o_rdy[0]), .tx_busy(o_busy[0]),
        .tx_done_tick(o_done[0]), .tx(o_tx[0]));
    uart_tx_frame #(.DBIT(8), .OVS(16), .SB_TICK(32)) u1 (
        .clk(clk), .reset(reset), .s_tick(ts[1]), .tx_start(st[1]), .din(dn[1][7:0]),
        .par_mode(pm[1]), .tx_ready(o_rdy[1]), .tx_busy(o_busy[1]),
        .tx_done_tick(o_done[1]), .tx(o_tx[1]));
    uart_tx_frame #(.DBIT(5), .OVS(16), .SB_TICK(16)) u2 (
        .clk(clk), .reset(reset), .s_tick(ts[2]), .tx_start(st[2]), .din(dn[2][4:0]),
        .par_mode(pm[2]), .tx_ready(o_rdy[2]), .tx_busy(o_busy[2]),
        .tx_done_tick(o_done[2]), .tx(o_tx[2]));

    typedef struct {
        int         d;
        logic [8:0] data;
        logic [1:0] pm;
        int         len;
        logic       par;
    } vec_t;

    function automatic logic [8:0] msk(input int d);
        return 9'((1 << db[d]) - 1);
    endfunction

    function automatic bit pen(input logic [1:0] p);
        return p == 2'b01 || p == 2'b10;
    endfunction

    function automatic int flen(input int d, input logic [1:0] p);
        return OVS * (1 + db[d] + (pen(p) ? 1 : 0)) + sb[d];
    endfunction

    // serial level implied by how many ticks of the current frame have elapsed
    function automatic logic exp_tx(input int d);
        int t;
        t = m_t[d];
        if (!m_busy[d]) return 1'b1;
        if (t < OVS) return 1'b0;
        if (t < OVS * (1 + db[d])) return m_dat[d][(t - OVS) / OVS];
        if (pen(m_pm[d]) && t < OVS * (2 + db[d])) return (^m_dat[d]) ^ (m_pm[d] == 2'b10);
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s dut%0d got=%0d exp=%0d at %0t", nm, d, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 3; d++) begin
            m_full[d] = 0; m_busy[d] = 0; m_rem[d] = 0; m_t[d] = 0;
            m_buf[d] = '0; m_dat[d] = '0; m_bpm[d] = '0; m_pm[d] = '0;
        end
    endtask

    task automatic model_step(input int d);
        bit fp, ended;
        fp    = m_full[d];
        ended = m_busy[d] && ts[d] && m_rem[d] == 1;
        if (m_busy[d] && ts[d]) begin
            m_rem[d]--;
            m_t[d]++;
        end
        if (ended) m_busy[d] = 0;
        if (fp && !m_busy[d]) begin
            m_busy[d] = 1;
            m_dat[d]  = m_buf[d] & msk(d);
            m_pm[d]   = m_bpm[d];
            m_rem[d]  = flen(d, m_bpm[d]);
            m_t[d]    = 0;
            m_full[d] = 0;
        end
        if (st[d] && !fp) begin
            m_full[d] = 1;
            m_buf[d]  = dn[d];
            m_bpm[d]  = pm[d];
        end
    endtask

    task automatic cyc();
        for (int d = 0; d < 3; d++)
            ts[d] = mode[d] == 0 ? 1'b1 : mode[d] == 1 ? (cc % 4 == 3) :
                    mode[d] == 2 ? 1'b0 : 1'($urandom_range(0, 1));
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("tx", d, o_tx[d], exp_tx(d));
            chk("ready", d, o_rdy[d], !m_full[d]);
            chk("busy", d, o_busy[d], m_busy[d]);
            chk("done", d, o_done[d], m_busy[d] && ts[d] && m_rem[d] == 1);
            s_tx[d] = o_tx[d]; s_rdy[d] = o_rdy[d]; s_busy[d] = o_busy[d];
            s_done[d] = o_done[d]; s_ts[d] = ts[d];
        end
        @(posedge clk);
        if (reset) for (int d = 0; d < 3; d++) model_step(d);
        #1;
        cc++;
    endtask

    task automatic send(input int d, input logic [8:0] data, input logic [1:0] p);
        st[d] = 1'b1; dn[d] = data; pm[d] = p;
        cyc();
        st[d] = 1'b0;
    endtask

    task automatic idle_chk(input string nm);
        for (int d = 0; d < 3; d++) begin
            chk({nm, "_tx"}, d, o_tx[d], 1);
            chk({nm, "_ready"}, d, o_rdy[d], 1);
            chk({nm, "_busy"}, d, o_busy[d], 0);
            chk({nm, "_done"}, d, o_done[d], 0);
        end
    endtask

    task automatic run_frame(input int d, input logic [8:0] data, input logic [1:0] p,
                             output int len, output logic [8:0] dec, output logic pb);
        logic smp[401];
        int   k, n;
        bit   got;
        k = 0; n = 0; got = 0; dec = '0;
        for (int i = 0; i < 401; i++) smp[i] = 1'b1;
        send(d, data, p);
        while (!got && n < 3000) begin
            cyc();
            n++;
            if (s_busy[d] && s_ts[d]) begin
                k++;
                if (k <= 400) smp[k] = s_tx[d];
            end
            if (s_done[d]) got = 1;
        end
        if (!got) chk("frame_timeout", d, 0, 1);
        len = k;
        for (int i = 0; i < db[d]; i++) dec[i] = smp[OVS * (1 + i) + OVS / 2];
        pb = smp[OVS * (1 + db[d]) + OVS / 2];
    endtask

    initial begin
        vec_t       tbl[6];
        int         len, n, dones, h, stp, ph;
        logic [8:0] dec;
        logic       pb, v;

        tbl[0] = '{0, 9'h055, 2'b00, 160, 1'b0};
        tbl[1] = '{0, 9'h007, 2'b01, 176, 1'b1};
        tbl[2] = '{0, 9'h007, 2'b10, 176, 1'b0};
        tbl[3] = '{0, 9'h003, 2'b01, 176, 1'b0};
        tbl[4] = '{2, 9'h01F, 2'b10, 128, 1'b0};
        tbl[5] = '{1, 9'h081, 2'b11, 176, 1'b0};

        checks = 0; failures = 0; cc = 0;
        for (int d = 0; d < 3; d++) begin
            st[d] = 0; ts[d] = 0; dn[d] = '0; pm[d] = '0; mode[d] = 0;
        end
        model_clear();
        reset = 1'b1;
        #1 reset = 1'b0;
        #2 idle_chk("reset");
        repeat (2) cyc();
        reset = 1'b1;
        repeat (3) cyc();

        foreach (tbl[i]) begin
            run_frame(tbl[i].d, tbl[i].data, tbl[i].pm, len, dec, pb);
            chk($sformatf("len%0d", i), tbl[i].d, len, tbl[i].len);
            chk($sformatf("data%0d", i), tbl[i].d, dec, tbl[i].data & msk(tbl[i].d));
            if (pen(tbl[i].pm)) chk($sformatf("par%0d", i), tbl[i].d, pb, tbl[i].par);
            repeat (3) cyc();
        end

        // back-to-back frames with an overflowing third write
        send(0, 9'h0A5, 2'b00);
        repeat (20) cyc();
        send(0, 9'h03C, 2'b00);
        chk("b2b_ready", 0, o_rdy[0], 0);
        repeat (10) cyc();
        send(0, 9'h0FF, 2'b00);
        dones = 0; n = 0;
        while (dones < 2 && n < 1000) begin
            cyc();
            n++;
            if (s_done[0]) begin
                dones++;
                if (dones == 1) begin
                    chk("b2b_start_tx", 0, o_tx[0], 0);
                    chk("b2b_start_busy", 0, o_busy[0], 1);
                end
            end
        end
        repeat (300) begin
            cyc();
            if (s_done[0]) dones++;
        end
        chk("b2b_done_count", 0, dones, 2);

        // tick every 4th clock: bit0 high time and stop length in clocks
        mode[1] = 1;
        send(1, 9'h001, 2'b00);
        h = 0; stp = 0; ph = 0; n = 0;
        while (ph < 4 && n < 3000) begin
            cyc();
            n++;
            if (ph == 0 && s_busy[1] && s_tx[1]) ph = 1;
            if (ph == 1) begin
                if (s_tx[1]) h++;
                else ph = 2;
            end
            if (ph == 2 && s_tx[1]) ph = 3;
            if (ph == 3) begin
                stp++;
                if (s_done[1]) ph = 4;
            end
        end
        chk("gate_phase", 1, ph, 4);
        chk("gate_bit_clk", 1, h, 64);
        chk("gate_stop_clk", 1, stp, 128);
        repeat (10) cyc();

        // freeze mid-bit with no ticks
        send(1, 9'h0F0, 2'b01);
        repeat (190) cyc();
        mode[1] = 2;
        v = o_tx[1];
        h = 0;
        repeat (100) begin
            cyc();
            if (s_tx[1] != v) h++;
        end
        chk("freeze_changes", 1, h, 0);
        chk("freeze_busy", 1, o_busy[1], 1);
        mode[1] = 1;
        n = 0;
        while (o_busy[1] && n < 3000) begin
            cyc();
            n++;
        end
        chk("freeze_drain", 1, o_busy[1], 0);

        // asynchronous reset in the middle of a data bit
        send(0, 9'h0AA, 2'b00);
        repeat (48) cyc();
        chk("pre_reset_busy", 0, o_busy[0], 1);
        #2 reset = 1'b0;
        #1 idle_chk("midrst");
        model_clear();
        repeat (3) cyc();
        reset = 1'b1;
        repeat (2) cyc();
        run_frame(0, 9'h081, 2'b00, len, dec, pb);
        chk("post_rst_len", 0, len, 160);
        chk("post_rst_data", 0, dec, 9'h081);

        // random traffic on all three, every cycle checked by the model
        mode[0] = 3; mode[1] = 1; mode[2] = 3;
        repeat (4000) begin
            for (int d = 0; d < 3; d++) begin
                st[d] = ($urandom_range(0, 19) == 0);
                dn[d] = 9'($urandom);
                pm[d] = 2'($urandom);
            end
            cyc();
        end
        for (int d = 0; d < 3; d++) st[d] = 1'b0;
        repeat (2000) cyc();
        for (int d = 0; d < 3; d++) chk("final_idle", d, o_busy[d], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
